product_bcd_converter: RTL and testbench
========================================

# product_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 8x8 shift-add multiplier. It captures the 16-bit product and converts it with the double-dabble (shift-and-add-3) algorithm, one bit per clock. It presents five packed BCD digits for the seven-segment display path. It also serves any other 16-bit unsigned result the datapath needs to display.

## Interface
Parameters:
- DATA_WIDTH, 16, width of the unsigned binary input.
- DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_WIDTH.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock is synchronous and reset is active-high, as already decided.
- in_valid  in  1  bin_in holds a value to convert.
- in_ready  out  1  converter can accept a value (high in IDLE and DONE).
- bin_in  in  DATA_WIDTH  unsigned binary value, normally the multiplier product.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (units) in [3:0], digit 4 in [19:16].
- out_valid  out  1  bcd_out holds the result of the most recent accepted value.

## Operation
- States: IDLE, CONVERT, DONE.
  - IDLE: in_ready=1, out_valid=0. On in_valid=1, load the binary shift register with bin_in, clear the BCD scratch register and the bit counter, and go to CONVERT.
  - CONVERT: in_ready=0; in_valid is ignored. Each cycle does two things:
    - Every scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
    - The {scratch, binary} register then shifts left one bit, so the binary MSB enters scratch bit 0.
    - The counter increments each cycle. When the counter reaches DATA_WIDTH-1 (the DATA_WIDTH-th shift), the post-shift scratch is written to bcd_out and the block goes to DONE.
  - DONE: out_valid=1, in_ready=1; bcd_out is held.
    - in_valid=1 loads the new value as in IDLE and goes to CONVERT; out_valid drops on that edge.
    - in_valid=0 stays in DONE indefinitely.
- bcd_out is a separate output register and only changes on completion or reset. Intermediate scratch values never appear on it.
- Width rules:
  - Scratch register is 4*DIGITS bits; the counter is clog2(DATA_WIDTH) bits.
  - The add-3 is applied before the shift and never to the final shifted value.
  - The top digit never exceeds 6 for 16-bit input; no overflow flag.
- Reset (any state, including mid-CONVERT) has these effects:
  - state=IDLE, bcd_out=0, out_valid=0, counter=0, scratch=0. in_ready reads 1 the cycle after reset.
  - An aborted conversion produces no output.
- Simultaneous reset and in_valid: reset wins; the value is not accepted.

## Timing
- Accept edge E0 is the rising edge with in_valid & in_ready. Shift edges are E1..E16.
- At E16, bcd_out is updated and out_valid rises, giving 16 cycles from accept to out_valid.
- Throughput: a new value can be accepted on the edge after out_valid rises, so back-to-back conversions run one per 17 cycles.
- in_ready and out_valid are decoded from registered state only; there are no combinational paths from in_valid.
- bin_in must be stable only at the accept edge.

## Structure
- Shared package product_bcd_pkg holds:
  - state encoding (IDLE=2'd0, CONVERT=2'd1, DONE=2'd2);
  - DATA_WIDTH and DIGITS defaults;
  - the BCD add-3 threshold constant (4'd5).
- One combinational sub-module, bcd_digit_adjust: 4-bit in, 4-bit out, outputs in+3 when in>=5, else passes in through. It is instantiated DIGITS times via generate.
- Top level holds the FSM, counter, shift registers and output register.

## Test plan
- After reset, 45 (the multiplier's 9x5 product) applied with in_valid for 1 cycle -> in_ready low for 16 cycles; at E16 bcd_out=20'h00045 and out_valid=1.
- 44000 (200x220 product) -> bcd_out=20'h44000 at E16.
- Boundaries: 0 -> 20'h00000 and 65535 -> 20'h65535, each with 16-cycle latency.
- in_valid held high continuously with values 1234 then 9999:
  - out_valid pulses one cycle per result;
  - results are 20'h01234 then 20'h09999;
  - the second value is accepted on the edge after the first out_valid rises, 17-cycle spacing;
  - in_valid toggling during CONVERT does not change the result.
- Reset asserted at E8 of converting 500, starting from a prior result of 20'h00045 -> next edge bcd_out=0, out_valid=0, in_ready=1; a new value 7 then yields 20'h00007.
- Reset and in_valid high on the same edge -> value not accepted; state IDLE and out_valid=0 on the following cycle.

Source files
------------

// File: rtl/product_bcd_pkg.sv
// Shared definitions for the product BCD converter: FSM encoding, size defaults, add-3 threshold.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package product_bcd_pkg;

    // Default sizing: 16-bit multiplier product into five BCD digits (10^5 > 2^16).
    localparam int PKG_DATA_WIDTH = 16;
    localparam int PKG_DIGITS     = 5;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // A digit at or above this value would reach 10 or more once shifted, so it gets +3 first.
    localparam logic [3:0] BCD_ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more, else passes it through.
// Latency: purely combinational.
// Backpressure: none.
// Ports: digit_in - scratch digit before the shift; digit_out - corrected digit.
module bcd_digit_adjust
    import product_bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // 4-bit add; a digit in 5..9 maps to 8..12, which never carries out of the nibble.
    assign digit_out = (digit_in >= BCD_ADD3_THRESHOLD) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) for the multiplier product.
// Latency: DATA_WIDTH cycles from the accept edge to out_valid; one conversion every DATA_WIDTH+1 cycles.
// Backpressure: in_ready is low while converting; in_valid is ignored until the result is presented.
// Ports: clock/reset (sync, active-high); in_valid/in_ready/bin_in input handshake;
//        bcd_out packed digits (units in [3:0]) with out_valid held high until the next accept.
module product_bcd_converter
    import product_bcd_pkg::*;
#(
    parameter int DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int DIGITS     = PKG_DIGITS
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam int              SW       = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [SW-1:0]         scratch;
    logic [SW-1:0]         scratch_adj;
    logic [SW-1:0]         scratch_shift;
    logic [DATA_WIDTH-1:0] bin_reg;
    logic [DATA_WIDTH-1:0] bin_shift;

    // Per-digit add-3 correction on the scratch register before each shift.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_in  (scratch[4*i +: 4]),
                .digit_out (scratch_adj[4*i +: 4])
            );
        end
    endgenerate

    // One left shift of the combined {scratch, binary} register; the binary MSB lands in scratch bit 0.
    assign {scratch_shift, bin_shift} = {scratch_adj, bin_reg} << 1;

    // Handshake outputs come from registered state only.
    assign in_ready  = (state == ST_IDLE) || (state == ST_DONE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            scratch <= '0;
            bin_reg <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (in_valid) begin
                        bin_reg <= bin_in;
                        scratch <= '0;
                        bit_cnt <= '0;
                        state   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    scratch <= scratch_shift;
                    bin_reg <= bin_shift;
                    bit_cnt <= bit_cnt + 1'b1;
                    // The last shift's result goes straight to the output register, so
                    // partial scratch values are never visible on bcd_out.
                    if (bit_cnt == LAST_CNT) begin
                        bcd_out <= scratch_shift;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: decimal reference model plus directed and random stimulus.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_product_bcd_converter;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin_in;
    logic [19:0] bcd_out;
    logic        out_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    product_bcd_converter dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .bcd_out   (bcd_out),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference conversion by plain decimal arithmetic.
    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: an accepted value is busy for 16 edges, then its decimal digits appear.
    int          rem;
    logic        exp_ovld;
    logic        exp_rdy;
    logic [19:0] exp_bcd;
    logic [15:0] pend;

    initial begin
        rem = 0; exp_ovld = 1'b0; exp_rdy = 1'b1; exp_bcd = '0; pend = '0;
    end

    always @(posedge clock) begin
        if (reset) begin
            rem = 0; exp_ovld = 1'b0; exp_rdy = 1'b1; exp_bcd = '0;
        end else if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) begin
                exp_bcd  = to_bcd(int'(pend));
                exp_ovld = 1'b1;
                exp_rdy  = 1'b1;
            end
        end else if (in_valid) begin
            pend     = bin_in;
            rem      = 16;
            exp_ovld = 1'b0;
            exp_rdy  = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("in_ready",  32'(in_ready),  32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(exp_ovld));
            check("bcd_out",   32'(bcd_out),   32'(exp_bcd));
        end
    end

    // Called at a negedge with in_ready high; leaves in_valid low after the accept edge.
    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        bin_in   = v;
        @(negedge clock);
        in_valid = 1'b0;
        bin_in   = 16'($urandom);
    endtask

    // Counts negedges until out_valid, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        if (!out_valid) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic directed(input string name, input logic [15:0] v, input logic [19:0] lit);
        int c;
        send(v);
        wait_done(c);
        check({name, "_latency"}, 32'(c), 32'd16);
        check({name, "_bcd"}, 32'(bcd_out), 32'(lit));
    endtask

    initial begin
        int c1, c2;
        reset    = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;

        // Model pinned by hand-computed values.
        check("model_45",    32'(to_bcd(45)),    32'h00045);
        check("model_65535", 32'(to_bcd(65535)), 32'h65535);

        // Reset state.
        check("rst_ready", 32'(in_ready),  32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd",   32'(bcd_out),   32'd0);

        directed("p45",    16'd45,    20'h00045);
        directed("p44000", 16'd44000, 20'h44000);
        directed("zero",   16'd0,     20'h00000);
        directed("max",    16'd65535, 20'h65535);

        // in_valid held high: back-to-back results 17 cycles apart.
        in_valid = 1'b1;
        bin_in   = 16'd1234;
        @(negedge clock);
        bin_in = 16'd9999;
        wait_done(c1);
        check("b2b_first_bcd", 32'(bcd_out), 32'h01234);
        @(negedge clock);
        check("b2b_pulse", 32'(out_valid), 32'd0);
        wait_done(c2);
        in_valid = 1'b0;
        check("b2b_spacing",    32'(c2 + 1), 32'd17);
        check("b2b_second_bcd", 32'(bcd_out), 32'h09999);

        // in_valid and bin_in toggling during a conversion must not disturb it.
        send(16'd321);
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'($urandom);
            bin_in   = 16'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b0;
        wait_done(c1);
        check("toggle_bcd", 32'(bcd_out), 32'h00321);

        // Abort mid-conversion.
        directed("pre_abort", 16'd45, 20'h00045);
        send(16'd500);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_bcd",   32'(bcd_out),   32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready),  32'd1);
        directed("after_abort", 16'd7, 20'h00007);

        // Reset and in_valid together: reset wins.
        reset    = 1'b1;
        in_valid = 1'b1;
        bin_in   = 16'd123;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rv_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("rv_not_accepted", 32'(in_ready), 32'd1);

        // Random traffic with occasional resets and boundary values.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       bin_in = 16'd0;
                1:       bin_in = 16'hFFFF;
                default: bin_in = 16'($urandom);
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 299) == 0);
            @(negedge clock);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (20) @(negedge clock);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
